// File: rtl/status_reg.sv
// status_reg: processor status register (N V - B D I Z C).
// Holds the six architectural flags and exposes P / P_push views, carry-in
// and the decimal-mode control to the ALU. ALU flag updates are requested in
// the issue cycle and applied one advancing edge later, when the ALU's
// registered flag outputs become valid.
// Optional feature: define DECIMAL_MODE_EN to make D a writable flag and to
// enable BCD; otherwise D and BCD are tied to 0.
module status_reg #(
  parameter logic [7:0] P_RESET = 8'h04
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RDY,
  input  logic       alu_CO,
  input  logic       alu_V,
  input  logic       alu_Z,
  input  logic       alu_N,
  input  logic       upd_nz,
  input  logic       upd_c,
  input  logic       upd_v,
  input  logic       bcd_op,
  input  logic       flag_we,
  input  logic [2:0] flag_sel,
  input  logic       flag_val,
  input  logic       load_p,
  input  logic [7:0] DI,
  input  logic       irq_entry,
  input  logic       brk,
  output logic [7:0] P,
  output logic [7:0] P_push,
  output logic       CI,
  output logic       BCD
);

  logic n_reg, v_reg, i_reg, z_reg, c_reg;
  logic n_next, v_next, i_next, z_next, c_next;
  logic pend_nz_reg, pend_c_reg, pend_v_reg;
  logic pend_nz_next, pend_c_next, pend_v_next;
  logic d_reg;

`ifdef DECIMAL_MODE_EN
  logic d_next;
`endif

  // Next flag values: writes applied lowest priority first so that later,
  // higher-priority sources overwrite earlier ones on the same flag.
  always_comb begin
    n_next = n_reg;
    v_next = v_reg;
    i_next = i_reg;
    z_next = z_reg;
    c_next = c_reg;
`ifdef DECIMAL_MODE_EN
    d_next = d_reg;
`endif
    // Pending ALU updates are captured every advancing edge; a flag reload
    // cancels them because the ALU result no longer belongs to this state.
    pend_nz_next = upd_nz & ~load_p;
    pend_c_next  = upd_c  & ~load_p;
    pend_v_next  = upd_v  & ~load_p;

    if (pend_nz_reg) begin
      n_next = alu_N;
      z_next = alu_Z;
    end
    if (pend_c_reg) begin
      c_next = alu_CO;
    end
    if (pend_v_reg) begin
      v_next = alu_V;
    end

    if (irq_entry) begin
      i_next = 1'b1;
    end

    if (flag_we) begin
      case (flag_sel)
        3'd0: c_next = flag_val;
        3'd1: z_next = flag_val;
        3'd2: i_next = flag_val;
        3'd3: begin
`ifdef DECIMAL_MODE_EN
          d_next = flag_val;
`endif
        end
        3'd6: v_next = flag_val;
        3'd7: n_next = flag_val;
        default: ;
      endcase
    end

    if (load_p) begin
      n_next = DI[7];
      v_next = DI[6];
      i_next = DI[2];
      z_next = DI[1];
      c_next = DI[0];
`ifdef DECIMAL_MODE_EN
      d_next = DI[3];
`endif
    end
  end

  // Flag and pending registers; everything freezes while RDY is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_reg       <= P_RESET[7];
      v_reg       <= P_RESET[6];
      i_reg       <= P_RESET[2];
      z_reg       <= P_RESET[1];
      c_reg       <= P_RESET[0];
      pend_nz_reg <= 1'b0;
      pend_c_reg  <= 1'b0;
      pend_v_reg  <= 1'b0;
    end else if (RDY) begin
      n_reg       <= n_next;
      v_reg       <= v_next;
      i_reg       <= i_next;
      z_reg       <= z_next;
      c_reg       <= c_next;
      pend_nz_reg <= pend_nz_next;
      pend_c_reg  <= pend_c_next;
      pend_v_reg  <= pend_v_next;
    end
  end

`ifdef DECIMAL_MODE_EN
  // Decimal flag register, same reset and stall behaviour as the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_reg <= P_RESET[3];
    end else if (RDY) begin
      d_reg <= d_next;
    end
  end

  assign BCD = d_reg & bcd_op;

  // DI[5:4] are the unimplemented / B positions and are never stored.
  logic unused_inputs;
  assign unused_inputs = ^DI[5:4];
`else
  assign d_reg = 1'b0;
  assign BCD   = 1'b0;

  // Without decimal mode the D bit of DI and bcd_op have no effect.
  logic unused_inputs;
  assign unused_inputs = ^{DI[5:3], bcd_op};
`endif

  assign P      = {n_reg, v_reg, 1'b1, 1'b1, d_reg, i_reg, z_reg, c_reg};
  assign P_push = {n_reg, v_reg, 1'b1, brk,  d_reg, i_reg, z_reg, c_reg};
  assign CI     = c_reg;

endmodule

// File: tb/tb_status_reg.sv
// tb_status_reg: directed bench for status_reg with a byte-level flag model
// and a per-cycle compare process, plus literal checks on key scenarios.
module tb_status_reg;

`ifdef DECIMAL_MODE_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       RDY;
  logic       alu_CO, alu_V, alu_Z, alu_N;
  logic       upd_nz, upd_c, upd_v;
  logic       bcd_op;
  logic       flag_we;
  logic [2:0] flag_sel;
  logic       flag_val;
  logic       load_p;
  logic [7:0] DI;
  logic       irq_entry;
  logic       brk;
  logic [7:0] P, P_push;
  logic       CI, BCD;

  int n_checks = 0;
  int n_fail   = 0;

  status_reg #(.P_RESET(8'h04)) dut (
    .clk(clk), .reset(reset), .RDY(RDY),
    .alu_CO(alu_CO), .alu_V(alu_V), .alu_Z(alu_Z), .alu_N(alu_N),
    .upd_nz(upd_nz), .upd_c(upd_c), .upd_v(upd_v),
    .bcd_op(bcd_op), .flag_we(flag_we), .flag_sel(flag_sel), .flag_val(flag_val),
    .load_p(load_p), .DI(DI), .irq_entry(irq_entry), .brk(brk),
    .P(P), .P_push(P_push), .CI(CI), .BCD(BCD)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Flags kept as one byte laid out like P with bits 5:4 held at zero; the set
  // of bits software may write depends on whether decimal mode exists.
  logic [7:0] wmask;
  logic [7:0] m_p;
  logic [2:0] m_pend;   // {nz, c, v} requested on the previous advancing edge
  logic [7:0] nb;

  initial wmask = DEC ? 8'hCF : 8'hC7;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_p    <= 8'h04 & wmask;
      m_pend <= 3'b000;
    end else if (RDY) begin
      nb = m_p;
      if (m_pend[2]) begin nb[7] = alu_N; nb[1] = alu_Z; end
      if (m_pend[1]) nb[0] = alu_CO;
      if (m_pend[0]) nb[6] = alu_V;
      if (irq_entry) nb[2] = 1'b1;
      if (flag_we && wmask[flag_sel]) nb[flag_sel] = flag_val;
      if (load_p) nb = DI & wmask;
      m_p    <= nb;
      m_pend <= load_p ? 3'b000 : {upd_nz, upd_c, upd_v};
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    n_checks++;
    if (P !== (m_p | 8'h30)) begin
      n_fail++;
      $display("FAIL model_P t=%0t got=%h exp=%h", $time, P, m_p | 8'h30);
    end
    n_checks++;
    if (P_push !== {m_p[7:6], 1'b1, brk, m_p[3:0]}) begin
      n_fail++;
      $display("FAIL model_P_push t=%0t got=%h exp=%h", $time, P_push,
               {m_p[7:6], 1'b1, brk, m_p[3:0]});
    end
    n_checks++;
    if (CI !== m_p[0]) begin
      n_fail++;
      $display("FAIL model_CI t=%0t got=%b exp=%b", $time, CI, m_p[0]);
    end
    n_checks++;
    if (BCD !== (m_p[3] & bcd_op)) begin
      n_fail++;
      $display("FAIL model_BCD t=%0t got=%b exp=%b", $time, BCD, m_p[3] & bcd_op);
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end else begin
      $display("ok   %s = %h", name, got);
    end
  endtask

  // Advance one edge; inputs are changed 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    upd_nz = 0; upd_c = 0; upd_v = 0; flag_we = 0; load_p = 0; irq_entry = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1; RDY = 1;
    alu_CO = 0; alu_V = 0; alu_Z = 0; alu_N = 0;
    clear_strobes();
    bcd_op = 0; flag_sel = 0; flag_val = 0; DI = 8'h00; brk = 0;
    tick(); tick();
    reset = 0;
    check("reset_P", P, 8'h34);

    // SEC, then an asynchronous reset between edges restores the reset value
    flag_we = 1; flag_sel = 3'd0; flag_val = 1; tick(); clear_strobes();
    check("sec_P", P, 8'h35);
    reset = 1; #1;
    check("async_reset_P", P, 8'h34);
    check("async_reset_CI", {7'b0, CI}, 8'h00);
    #1 reset = 0;
    tick();

    // ALU N/Z/C update lands one edge after the request
    upd_nz = 1; upd_c = 1; tick(); clear_strobes();
    check("nzc_not_yet", P, 8'h34);
    alu_N = 1; alu_Z = 0; alu_CO = 1; tick();
    check("nzc_applied_P", P, 8'hB5);
    alu_N = 0; alu_CO = 0;
    tick();
    check("nzc_no_repeat", P, 8'hB5);

    // V update held across a 3-cycle stall
    upd_v = 1; tick(); clear_strobes();
    RDY = 0; alu_V = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("v_stalled", {7'b0, P[6]}, 8'h00);
    end
    RDY = 1; tick();
    check("v_after_rdy", P, 8'hF5);
    alu_V = 0;

    // load_p beats flag_we and cancels in-flight ALU updates
    upd_c = 1; tick(); clear_strobes();
    load_p = 1; DI = 8'hFF; flag_we = 1; flag_sel = 3'd0; flag_val = 0;
    upd_nz = 1; alu_CO = 0; tick(); clear_strobes();
    check("load_p_P", P, DEC ? 8'hFF : 8'hF7);
    alu_N = 0; alu_Z = 1; alu_CO = 0; tick();
    check("load_p_cancel", P, DEC ? 8'hFF : 8'hF7);
    alu_Z = 0;

    // CLD / SED and the BCD/B outputs
    flag_we = 1; flag_sel = 3'd3; flag_val = 0; tick(); clear_strobes();
    check("cld_P", P, 8'hF7);
    flag_we = 1; flag_sel = 3'd3; flag_val = 1; tick(); clear_strobes();
    bcd_op = 1; brk = 1; #1;
    check("sed_BCD", {7'b0, BCD}, DEC ? 8'h01 : 8'h00);
    check("brk_push4", {7'b0, P_push[4]}, 8'h01);
    check("brk_P4", {7'b0, P[4]}, 8'h01);
    bcd_op = 0; brk = 0;

    // flag_we over irq_entry on I; unused selects do nothing
    flag_we = 1; flag_sel = 3'd2; flag_val = 0; irq_entry = 1; tick(); clear_strobes();
    check("clI_beats_irq", {7'b0, P[2]}, 8'h00);
    flag_we = 1; flag_sel = 3'd5; flag_val = 0; tick(); clear_strobes();
    check("sel5_noop", P, DEC ? 8'hFB : 8'hF3);
    irq_entry = 1; tick(); clear_strobes();
    check("irq_sets_I", {7'b0, P[2]}, 8'h01);

    // pending C vs flag_we C, while a pending NZ hits other flags
    upd_c = 1; upd_nz = 1; tick(); clear_strobes();
    alu_CO = 0; alu_N = 0; alu_Z = 1;
    flag_we = 1; flag_sel = 3'd0; flag_val = 1; tick(); clear_strobes();
    check("mixed_P", P, DEC ? 8'h7F : 8'h77);
    alu_Z = 0;

    // reset mid-operation discards a pending update
    upd_c = 1; tick(); clear_strobes();
    alu_CO = 1; reset = 1; #1 reset = 0;
    tick();
    check("reset_drops_pend", P, 8'h34);
    alu_CO = 0;

    // randomised traffic checked by the compare process
    for (int k = 0; k < 300; k++) begin
      RDY = ($urandom_range(0, 3) != 0);
      alu_CO = 1'($urandom); alu_V = 1'($urandom);
      alu_Z = 1'($urandom);  alu_N = 1'($urandom);
      upd_nz = 1'($urandom); upd_c = 1'($urandom); upd_v = 1'($urandom);
      bcd_op = 1'($urandom); brk = 1'($urandom);
      flag_we = ($urandom_range(0, 3) == 0);
      flag_sel = 3'($urandom); flag_val = 1'($urandom);
      load_p = ($urandom_range(0, 7) == 0);
      DI = 8'($urandom);
      irq_entry = ($urandom_range(0, 5) == 0);
      tick();
    end
    clear_strobes();
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
